simon_input_checker: RTL and testbench
======================================

// Module: simon_input_checker
// PURPOSE
//  Receive side of the Simon sequence: after the Simon player has shown N colours,
//  this block accepts the player's button events (num/pressed from btnInterpreter),
//  compares each press against the stored sequence and reports round pass, mismatch
//  or inactivity timeout. It sits between btnInterpreter and the Simon sequence store.
// PARAMETERS
//  MAX_LEN   32  maximum sequence length (sequence memory depth)
//  ADDR_W     5  sequence address width, clog2(MAX_LEN)
//  TIMEOUT   10  tick pulses allowed between presses before timeout
// PORTS
//  clk            in   1       system clock, single clock domain
//  reset          in   1       asynchronous, active-low reset
//  tick           in   1       1-cycle timebase strobe for the timeout counter
//  start          in   1       1-cycle pulse: begin checking a round
//  seq_len        in   ADDR_W+1  round length, sampled on start
//  rd_addr        out  ADDR_W  sequence memory read address
//  rd_data        in   2       colour at rd_addr, valid 1 cycle after rd_addr changes
//  player_num     in   2       encoded button from btnInterpreter
//  player_pressed in   1       button held (level)
//  busy           out  1       round in progress
//  expected_idx   out  ADDR_W  index of next expected press
//  round_ok       out  1       1-cycle pulse: all seq_len presses matched
//  mismatch       out  1       1-cycle pulse: wrong colour pressed
//  timed_out      out  1       1-cycle pulse: no press within TIMEOUT ticks
//  game_over      out  1       level, set on mismatch/timeout
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; rd_addr, expected_idx, timeout count = 0;
//   busy, round_ok, mismatch, timed_out, game_over = 0; press_prev = 1.
//  press_prev registers player_pressed every cycle; press edge = pressed & ~press_prev.
//   A button already held when a round starts is ignored until released.
//  States:
//   IDLE: start & seq_len==0 -> round_ok next cycle, stay IDLE. start & seq_len>0 ->
//    len=min(seq_len,MAX_LEN), idx=0, rd_addr=0, game_over=0, busy=1, -> WAIT_PRESS.
//    start while busy is ignored.
//   WAIT_PRESS: tick increments timeout count; count==TIMEOUT-1 and tick -> FAIL,
//    timed_out pulse. Press edge -> capture player_num, clear count, -> CHECK.
//    Edge and final tick in same cycle: press wins.
//   CHECK (1 cycle): captured != rd_data -> FAIL, mismatch pulse; else -> WAIT_RELEASE.
//   WAIT_RELEASE: wait player_pressed==0 (no timeout here). Then if idx==len-1 ->
//    round_ok pulse, busy=0, -> IDLE; else idx++, rd_addr=idx+1, -> WAIT_PRESS.
//   FAIL: game_over=1, busy=0, -> IDLE. game_over held until next accepted start.
//  rd_addr is stable >=1 cycle before any compare (min 2 cycles WAIT_PRESS->CHECK), so
//   rd_data is always valid in CHECK. expected_idx == idx at all times.
//  Pulses are exactly one cycle; never two pulses in one cycle.
//  Latency: press edge -> mismatch 2 cycles; final release -> round_ok 1 cycle.
//  Reset mid-round: immediate return to reset values; no pulse emitted.
//  Presses arriving in CHECK/WAIT_RELEASE/IDLE/FAIL are ignored (not queued).
// STRUCTURE
//  simon_pkg: state encoding (IDLE, WAIT_PRESS, CHECK, WAIT_RELEASE, FAIL),
//   COLOUR_W=2, MAX_LEN/ADDR_W defaults shared with Simon and sequence store.
//  One sub-module: simon_timeout (tick counter, clear, expire pulse). Rest is one FSM.
// TESTING
//  1 seq {2,0,3}, len=3, correct presses each released -> round_ok once after 3rd
//    release, busy 1->0, game_over=0.
//  2 seq {1,1}, presses 1 then 2 -> mismatch 2 cycles after 2nd edge, game_over=1,
//    expected_idx=1, no round_ok.
//  3 TIMEOUT=10, start then no press -> timed_out on 10th tick, game_over=1;
//    press edge coinciding with 10th tick -> no timeout, CHECK proceeds.
//  4 player_pressed held high across start -> no compare until release and new press.
//  5 start with seq_len=0 -> round_ok next cycle; seq_len=40 -> len clamped to 32;
//    start while busy -> ignored.
//  6 reset low during WAIT_RELEASE -> all outputs 0 asynchronously; new start works.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared Simon definitions: colour width, sequence sizing defaults and the
// input-checker state encoding.
package simon_pkg;

  localparam int COLOUR_W    = 2;
  localparam int DEF_MAX_LEN = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_TIMEOUT = 10;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE         = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_PRESS   = 3'd1;
  localparam logic [STATE_W-1:0] ST_CHECK        = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_RELEASE = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAIL         = 3'd4;

endpackage

// File: rtl/simon_input_checker_timeout.sv
// Inactivity timer: counts tick strobes and pulses expire on the TIMEOUT-th
// tick since the last clear.
module simon_timeout
  import simon_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // clear has priority so a press on the final tick never reports expiry
  assign expire = tick & ~clear & (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/simon_input_checker.sv
// Simon receive side: compares player button presses against the stored
// sequence and reports round pass, mismatch or inactivity timeout.
module simon_input_checker
  import simon_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic [ADDR_W:0]     seq_len,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [COLOUR_W-1:0] rd_data,
  input  logic [COLOUR_W-1:0] player_num,
  input  logic                player_pressed,
  output logic                busy,
  output logic [ADDR_W-1:0]   expected_idx,
  output logic                round_ok,
  output logic                mismatch,
  output logic                timed_out,
  output logic                game_over
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);

  logic [STATE_W-1:0]  state;
  logic                press_prev;
  logic                press_edge;
  logic [COLOUR_W-1:0] captured;
  logic [ADDR_W:0]     len;
  logic [ADDR_W-1:0]   idx;
  logic                last_press;
  logic [ADDR_W:0]     clamped_len;
  logic                to_clear;
  logic                to_expire;

  assign press_edge   = player_pressed & ~press_prev;
  assign last_press   = ((ADDR_W+1)'(idx) == (len - (ADDR_W+1)'(1)));
  assign clamped_len  = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
  assign expected_idx = idx;

  // timer only runs while waiting for a press and restarts on every accepted edge
  assign to_clear = (state != ST_WAIT_PRESS) | press_edge;

  simon_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .clear  (to_clear),
    .expire (to_expire)
  );

  // reset value of 1 hides a button that is already held when the round begins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_prev <= 1'b1;
    end else begin
      press_prev <= player_pressed;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      idx       <= '0;
      len       <= '0;
      captured  <= '0;
      busy      <= 1'b0;
      round_ok  <= 1'b0;
      mismatch  <= 1'b0;
      timed_out <= 1'b0;
      game_over <= 1'b0;
    end else begin
      round_ok  <= 1'b0;
      mismatch  <= 1'b0;
      timed_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (seq_len == '0) begin
              round_ok <= 1'b1;
            end else begin
              len       <= clamped_len;
              idx       <= '0;
              rd_addr   <= '0;
              game_over <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_WAIT_PRESS;
            end
          end
        end

        ST_WAIT_PRESS: begin
          if (press_edge) begin
            captured <= player_num;
            state    <= ST_CHECK;
          end else if (to_expire) begin
            timed_out <= 1'b1;
            state     <= ST_FAIL;
          end
        end

        ST_CHECK: begin
          if (captured != rd_data) begin
            mismatch <= 1'b1;
            state    <= ST_FAIL;
          end else begin
            state <= ST_WAIT_RELEASE;
          end
        end

        ST_WAIT_RELEASE: begin
          if (!player_pressed) begin
            if (last_press) begin
              round_ok <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              idx     <= idx + ADDR_W'(1);
              rd_addr <= idx + ADDR_W'(1);
              state   <= ST_WAIT_PRESS;
            end
          end
        end

        ST_FAIL: begin
          game_over <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_input_checker.sv
// Self-checking bench for simon_input_checker: directed round scenarios plus
// randomized play compared every cycle against a round-level reference model.
module tb_simon_input_checker;

  localparam int TO_TICKS = 10;
  localparam int LEN_CAP  = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [5:0] seq_len = '0;
  logic [4:0] rd_addr;
  logic [1:0] rd_data;
  logic [1:0] player_num = '0;
  logic       player_pressed = 1'b0;
  logic       busy;
  logic [4:0] expected_idx;
  logic       round_ok;
  logic       mismatch;
  logic       timed_out;
  logic       game_over;

  logic [1:0] mem [LEN_CAP];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_round_ok = 0;
  int n_mismatch = 0;
  int n_timed_out = 0;
  int last_mismatch_cyc = -1;
  int edge_cyc = 0;

  // reference model of the round, advanced once per clock
  logic m_busy, m_game_over, m_round_ok, m_mismatch, m_timed_out;
  logic prev_pressed, active, need_release, pending_check, pending_fail;
  logic [1:0] captured_colour;
  int m_idx, m_len, ticks_left;

  simon_input_checker dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .start          (start),
    .seq_len        (seq_len),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .player_num     (player_num),
    .player_pressed (player_pressed),
    .busy           (busy),
    .expected_idx   (expected_idx),
    .round_ok       (round_ok),
    .mismatch       (mismatch),
    .timed_out      (timed_out),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) rd_data <= mem[rd_addr];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_game_over = 0; m_round_ok = 0; m_mismatch = 0; m_timed_out = 0;
      prev_pressed = 1; active = 0; need_release = 0; pending_check = 0; pending_fail = 0;
      m_idx = 0; m_len = 0; ticks_left = TO_TICKS; captured_colour = 0;
    end else begin
      m_round_ok = 0; m_mismatch = 0; m_timed_out = 0;
      if (pending_fail) begin
        pending_fail = 0; active = 0; m_game_over = 1; m_busy = 0;
      end else if (pending_check) begin
        pending_check = 0;
        if (captured_colour != mem[m_idx]) begin
          m_mismatch = 1; pending_fail = 1;
        end else begin
          need_release = 1;
        end
      end else if (need_release) begin
        if (!player_pressed) begin
          need_release = 0;
          if (m_idx == m_len - 1) begin
            m_round_ok = 1; m_busy = 0; active = 0;
          end else begin
            m_idx++; ticks_left = TO_TICKS;
          end
        end
      end else if (active) begin
        if (player_pressed && !prev_pressed) begin
          captured_colour = player_num; pending_check = 1;
        end else if (tick) begin
          ticks_left--;
          if (ticks_left == 0) begin
            m_timed_out = 1; pending_fail = 1;
          end
        end
      end else if (start) begin
        if (seq_len == 0) begin
          m_round_ok = 1;
        end else begin
          m_len = (seq_len > LEN_CAP) ? LEN_CAP : int'(seq_len);
          m_idx = 0; m_game_over = 0; m_busy = 1; active = 1; ticks_left = TO_TICKS;
        end
      end
      prev_pressed = player_pressed;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (round_ok) n_round_ok++;
    if (mismatch) begin n_mismatch++; last_mismatch_cyc = cyc; end
    if (timed_out) n_timed_out++;
    if (reset) begin
      checkOutput("busy", busy, m_busy);
      checkOutput("game_over", game_over, m_game_over);
      checkOutput("expected_idx", expected_idx, m_idx);
      checkOutput("rd_addr", rd_addr, m_idx);
      checkOutput("round_ok", round_ok, m_round_ok);
      checkOutput("mismatch", mismatch, m_mismatch);
      checkOutput("timed_out", timed_out, m_timed_out);
      checkOutput("single_pulse", 32'(round_ok) + 32'(mismatch) + 32'(timed_out) <= 1, 1);
    end
  end

  task automatic applyStimulus(input logic t, input logic s, input logic [5:0] l,
                               input logic p, input logic [1:0] n);
    tick = t; start = s; seq_len = l; player_pressed = p; player_num = n;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, player_pressed, player_num);
  endtask

  task automatic doStart(input logic [5:0] l);
    applyStimulus(0, 1, l, player_pressed, player_num);
  endtask

  task automatic press(input logic [1:0] c);
    edge_cyc = cyc;
    applyStimulus(0, 0, 0, 1, c);
    applyStimulus(0, 0, 0, 1, c);
    applyStimulus(0, 0, 0, 0, c);
    applyStimulus(0, 0, 0, 0, c);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, m0, t0;
    for (int i = 0; i < LEN_CAP; i++) mem[i] = 2'($urandom_range(0, 3));

    idle(3);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_game_over", game_over, 0);
    checkOutput("reset_expected_idx", expected_idx, 0);
    checkOutput("reset_rd_addr", rd_addr, 0);
    checkOutput("reset_pulses", {round_ok, mismatch, timed_out}, 0);
    reset = 1'b1;
    idle(2);

    // correct three-colour round
    mem[0] = 2; mem[1] = 0; mem[2] = 3;
    r0 = n_round_ok;
    doStart(3);
    checkOutput("s1_busy_set", busy, 1);
    press(2); press(0); press(3);
    checkOutput("s1_round_ok_once", n_round_ok - r0, 1);
    checkOutput("s1_busy_clear", busy, 0);
    checkOutput("s1_game_over", game_over, 0);

    // wrong second colour
    mem[0] = 1; mem[1] = 1;
    r0 = n_round_ok; m0 = n_mismatch;
    doStart(2);
    press(1); press(2);
    checkOutput("s2_mismatch_once", n_mismatch - m0, 1);
    checkOutput("s2_mismatch_latency", last_mismatch_cyc - edge_cyc, 2);
    checkOutput("s2_game_over", game_over, 1);
    checkOutput("s2_expected_idx", expected_idx, 1);
    checkOutput("s2_no_round_ok", n_round_ok - r0, 0);

    // inactivity timeout on the tenth tick
    mem[0] = 2;
    t0 = n_timed_out;
    doStart(1);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("s3_no_early_timeout", n_timed_out - t0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("s3_timeout_on_10th", n_timed_out - t0, 1);
    idle(2);
    checkOutput("s3_game_over", game_over, 1);
    checkOutput("s3_busy", busy, 0);

    // press coinciding with the final tick wins
    t0 = n_timed_out; r0 = n_round_ok;
    doStart(1);
    checkOutput("s3b_game_over_cleared", game_over, 0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("s3b_no_timeout", n_timed_out - t0, 0);
    checkOutput("s3b_round_ok", n_round_ok - r0, 1);

    // button held across start is ignored until released
    mem[0] = 1;
    m0 = n_mismatch; r0 = n_round_ok;
    applyStimulus(0, 0, 0, 1, 2);
    applyStimulus(0, 1, 1, 1, 2);
    repeat (4) applyStimulus(0, 0, 0, 1, 2);
    checkOutput("s4_held_no_compare", n_mismatch - m0, 0);
    checkOutput("s4_busy", busy, 1);
    applyStimulus(0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 2);
    press(1);
    checkOutput("s4_after_release", n_round_ok - r0, 1);
    checkOutput("s4_no_mismatch", n_mismatch - m0, 0);

    // zero length, clamped length and start while busy
    r0 = n_round_ok;
    doStart(0);
    checkOutput("s5_zero_len_round_ok", n_round_ok - r0, 1);
    checkOutput("s5_zero_len_busy", busy, 0);
    for (int i = 0; i < LEN_CAP; i++) mem[i] = 2'($urandom_range(0, 3));
    r0 = n_round_ok;
    doStart(40);
    press(mem[0]);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s5_start_busy_ignored", busy, 1);
    checkOutput("s5_start_busy_idx", expected_idx, 1);
    for (int i = 1; i < LEN_CAP; i++) press(mem[i]);
    checkOutput("s5_clamped_round_ok", n_round_ok - r0, 1);
    checkOutput("s5_clamped_busy", busy, 0);

    // asynchronous reset while waiting for release
    doStart(3);
    press(mem[0]);
    applyStimulus(0, 0, 0, 1, mem[1]);
    applyStimulus(0, 0, 0, 1, mem[1]);
    checkOutput("s6_idx_before_reset", expected_idx, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("s6_async_busy", busy, 0);
    checkOutput("s6_async_idx", expected_idx, 0);
    checkOutput("s6_async_rd_addr", rd_addr, 0);
    checkOutput("s6_async_flags", {round_ok, mismatch, timed_out, game_over}, 0);
    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    r0 = n_round_ok;
    doStart(1);
    press(mem[0]);
    checkOutput("s6_restart_round_ok", n_round_ok - r0, 1);

    // randomized play, with lazy stretches to provoke timeouts
    for (int blk = 0; blk < 12; blk++) begin
      for (int c = 0; c < 250; c++) begin
        logic t, s, p;
        logic [5:0] l;
        logic [1:0] n;
        t = ($urandom_range(0, 3) == 0);
        s = ($urandom_range(0, 19) == 0);
        l = ($urandom_range(0, 9) == 0) ? 6'd40 : 6'($urandom_range(0, 5));
        p = player_pressed;
        n = player_num;
        if ($urandom_range(0, (blk % 3 == 2) ? 40 : 2) == 0) begin
          p = ~player_pressed;
          if (p) n = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : mem[m_idx];
        end
        reset = ($urandom_range(0, 499) != 0);
        applyStimulus(t, s, l, p, n);
      end
    end
    reset = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
